// File: rtl/audio_pkg.sv
// Shared widths, PWM period and sample type for the audio sample output path.
package audio_pkg;

  localparam int unsigned SAMPLE_W   = 5;
  localparam int unsigned VOL_W      = 4;
  localparam int unsigned PWM_PERIOD = 30;

  typedef logic [SAMPLE_W-1:0] sample_t;

  // Two-channel mixer: each gated volume is zero-extended and summed (max 30, never wraps).
  function automatic sample_t mix(input logic ch0_bit, input logic [VOL_W-1:0] audv0,
                                  input logic ch1_bit, input logic [VOL_W-1:0] audv1);
    sample_t a;
    sample_t b;
    a = ch0_bit ? sample_t'(audv0) : '0;
    b = ch1_bit ? sample_t'(audv1) : '0;
    return a + b;
  endfunction

endpackage

// File: rtl/sample_fifo.sv
// First-word-fall-through sample FIFO with a separate occupancy counter.
module sample_fifo
  import audio_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          push,
  input  logic                          pop,
  input  sample_t                       din,
  output sample_t                       dout,
  output logic                          full,
  output logic                          empty,
  output logic [$clog2(FIFO_DEPTH):0]   level
);

  localparam int unsigned AW = $clog2(FIFO_DEPTH);
  localparam int unsigned LW = AW + 1;

  sample_t         mem [FIFO_DEPTH];
  logic [AW-1:0]   wr_ptr_q, rd_ptr_q;
  logic [LW-1:0]   level_q;
  logic            do_push, do_pop;

  assign full  = (level_q == LW'(FIFO_DEPTH));
  assign empty = (level_q == '0);
  assign level = level_q;

  // A push into a full FIFO is accepted only when the head leaves in the same cycle.
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);

  // Zero when empty so the head reads 0 during and after reset.
  assign dout = empty ? '0 : mem[rd_ptr_q];

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr_q] <= din;
    end
  end

  // Power-of-two depth: pointer overflow is the modulo wrap.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      unique case ({do_push, do_pop})
        2'b10:   level_q <= level_q + 1'b1;
        2'b01:   level_q <= level_q - 1'b1;
        default: level_q <= level_q;
      endcase
    end
  end

endmodule

// File: rtl/audio_sample_out.sv
// Two-channel mixer feeding a sample FIFO, with an optional PWM DAC enabled by AUDIO_PWM_EN.
module audio_sample_out
  import audio_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          ch0_bit,
  input  logic                          ch1_bit,
  input  logic [3:0]                    audv0,
  input  logic [3:0]                    audv1,
  input  logic                          sample_tick,
  output logic                          m_valid,
  input  logic                          m_ready,
  output logic [4:0]                    m_data,
  output logic [$clog2(FIFO_DEPTH):0]   level,
  output logic                          ovf,
  input  logic                          ovf_clr,
  output logic                          pwm_out
);

  sample_t sample;
  logic    full, empty, pop, ovf_set, ovf_q;

  assign sample  = mix(ch0_bit, audv0, ch1_bit, audv1);
  assign pop     = m_valid & m_ready;
  assign m_valid = ~empty;
  assign ovf_set = sample_tick & full & ~pop;
  assign ovf     = ovf_q;

  sample_fifo #(
    .FIFO_DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (sample_tick),
    .pop   (pop),
    .din   (sample),
    .dout  (m_data),
    .full  (full),
    .empty (empty),
    .level (level)
  );

  // A fresh overflow wins over a simultaneous clear.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ovf_q <= 1'b0;
    end else if (ovf_set) begin
      ovf_q <= 1'b1;
    end else if (ovf_clr) begin
      ovf_q <= 1'b0;
    end
  end

`ifdef AUDIO_PWM_EN
  logic [4:0] cnt_q, duty_q;
  sample_t    last_q;
  logic       pwm_q;
  logic       pushed, wrap;

  assign pushed  = sample_tick & (~full | pop);
  assign wrap    = (cnt_q == 5'(PWM_PERIOD - 1));
  assign pwm_out = pwm_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q  <= '0;
      duty_q <= '0;
      last_q <= '0;
      pwm_q  <= 1'b0;
    end else begin
      if (pushed) last_q <= sample;
      cnt_q <= wrap ? '0 : cnt_q + 1'b1;
      if (wrap) duty_q <= last_q;
      pwm_q <= (cnt_q < duty_q);
    end
  end
`else
  assign pwm_out = 1'b0;
`endif

endmodule

// File: tb/tb_audio_sample_out.sv
// Directed self-checking bench for audio_sample_out (default depth 4).
module tb_audio_sample_out;

  logic       clk = 1'b0;
  logic       rst;
  logic       ch0_bit, ch1_bit;
  logic [3:0] audv0, audv1;
  logic       sample_tick, m_ready, ovf_clr;
  logic       m_valid, ovf, pwm_out;
  logic [4:0] m_data;
  logic [2:0] level;

  int n_vec = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  audio_sample_out #(
    .FIFO_DEPTH (4)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .ch0_bit     (ch0_bit),
    .ch1_bit     (ch1_bit),
    .audv0       (audv0),
    .audv1       (audv1),
    .sample_tick (sample_tick),
    .m_valid     (m_valid),
    .m_ready     (m_ready),
    .m_data      (m_data),
    .level       (level),
    .ovf         (ovf),
    .ovf_clr     (ovf_clr),
    .pwm_out     (pwm_out)
  );

  task automatic check(input string tag, input int obs, input int exp);
    n_vec++;
    assert (obs === exp)
    else begin
      n_bad++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Apply one tick of a channel-0-only sample with volume v.
  task automatic tick0(input logic [3:0] v, input logic rdy);
    ch0_bit = 1'b1; audv0 = v; ch1_bit = 1'b0; audv1 = 4'd0;
    sample_tick = 1'b1; m_ready = rdy;
    step();
    sample_tick = 1'b0; m_ready = 1'b0;
  endtask

  task automatic pop_one();
    m_ready = 1'b1;
    step();
    m_ready = 1'b0;
  endtask

  initial begin
    int highs;
    rst = 1'b1; ch0_bit = 0; ch1_bit = 0; audv0 = 0; audv1 = 0;
    sample_tick = 0; m_ready = 0; ovf_clr = 0;
    #12;
    check("rst_level", level, 0);
    check("rst_valid", m_valid, 0);
    check("rst_data", m_data, 0);
    check("rst_ovf", ovf, 0);
    check("rst_pwm", pwm_out, 0);
    rst = 1'b0;
    step();

    // Both channels at full volume.
    ch0_bit = 1; audv0 = 15; ch1_bit = 1; audv1 = 15; sample_tick = 1;
    step();
    sample_tick = 0;
    check("max_valid", m_valid, 1);
    check("max_data", m_data, 30);
    check("max_level", level, 1);
    pop_one();
    check("max_popped_valid", m_valid, 0);

    // Channel 1 gated off.
    ch0_bit = 1; audv0 = 7; ch1_bit = 0; audv1 = 9; sample_tick = 1;
    step();
    sample_tick = 0;
    check("ch0only_data", m_data, 7);
    step();
    check("hold_data", m_data, 7);
    check("hold_valid", m_valid, 1);
    pop_one();

    // Other mixes.
    ch0_bit = 1; audv0 = 10; ch1_bit = 1; audv1 = 5; sample_tick = 1;
    step();
    ch0_bit = 0; audv0 = 10; ch1_bit = 1; audv1 = 6;
    step();
    ch0_bit = 0; ch1_bit = 0; audv0 = 15; audv1 = 15;
    step();
    sample_tick = 0;
    check("mix_level", level, 3);
    check("mix_a", m_data, 15); pop_one();
    check("mix_b", m_data, 6);  pop_one();
    check("mix_c", m_data, 0);  pop_one();
    check("mix_empty", m_valid, 0);

    // Overflow: five ticks into depth 4.
    tick0(4'd1, 0); tick0(4'd2, 0); tick0(4'd3, 0); tick0(4'd4, 0);
    check("fill_level", level, 4);
    check("fill_noovf", ovf, 0);
    tick0(4'd5, 0);
    check("ovf_level", level, 4);
    check("ovf_set", ovf, 1);
    check("ovf_o1", m_data, 1); pop_one();
    check("ovf_o2", m_data, 2); pop_one();
    check("ovf_o3", m_data, 3); pop_one();
    check("ovf_o4", m_data, 4); pop_one();
    check("ovf_drained", level, 0);
    check("ovf_sticky", ovf, 1);

    // Clear coinciding with a new overflow keeps the flag.
    tick0(4'd1, 0); tick0(4'd2, 0); tick0(4'd3, 0); tick0(4'd4, 0);
    ovf_clr = 1;
    tick0(4'd6, 0);
    check("clr_vs_set", ovf, 1);
    step();
    ovf_clr = 0;
    check("clr", ovf, 0);

    // Tick plus pop while full: no overflow, new sample at the tail.
    tick0(4'd9, 1);
    check("tp_level", level, 4);
    check("tp_ovf", ovf, 0);
    check("tp_o1", m_data, 2); pop_one();
    check("tp_o2", m_data, 3); pop_one();
    check("tp_o3", m_data, 4); pop_one();
    check("tp_o4", m_data, 9); pop_one();
    check("tp_empty", m_valid, 0);

    // Async reset at level 3 with ovf set.
    tick0(4'd1, 0); tick0(4'd2, 0); tick0(4'd3, 0); tick0(4'd4, 0); tick0(4'd5, 0);
    pop_one();
    check("pre_rst_level", level, 3);
    check("pre_rst_ovf", ovf, 1);
    #2;
    rst = 1'b1;
    #1;
    check("arst_level", level, 0);
    check("arst_valid", m_valid, 0);
    check("arst_ovf", ovf, 0);
    check("arst_data", m_data, 0);
    step();
    rst = 1'b0;
    step();
    tick0(4'd11, 0);
    check("post_rst_valid", m_valid, 1);
    check("post_rst_data", m_data, 11);
    check("post_rst_level", level, 1);
    pop_one();

    // PWM: sample 12 pushed, then count high cycles over one period after a wrap.
    tick0(4'd12, 0);
    for (int i = 0; i < 62; i++) step();
    highs = 0;
    for (int i = 0; i < 30; i++) begin
      if (pwm_out === 1'b1) highs++;
      step();
    end
`ifdef AUDIO_PWM_EN
    check("pwm_high", highs, 12);
`else
    check("pwm_tied", highs, 0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: observed running expected finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/audio_sample_out.md
AUDIO_SAMPLE_OUT -- requirements
Module: audio_sample_out

Interface
REQ-001 The block SHALL have parameter FIFO_DEPTH, default 4, meaning the sample FIFO depth (power of two, 2..16).
REQ-002 The block SHALL have port clk, input, 1 bit: the single system clock; all state updates on its rising edge.
REQ-003 The block SHALL have port rst, input, 1 bit: reset, asynchronous, active-high.
REQ-004 The block SHALL have port ch0_bit, input, 1 bit: channel-0 tone/noise output bit (shift_reg[0] of channel-0 generator).
REQ-005 The block SHALL have port ch1_bit, input, 1 bit: channel-1 tone/noise output bit.
REQ-006 The block SHALL have port audv0, input, 4 bits: channel-0 volume.
REQ-007 The block SHALL have port audv1, input, 4 bits: channel-1 volume.
REQ-008 The block SHALL have port sample_tick, input, 1 bit: one-cycle sample-rate strobe.
REQ-009 The block SHALL have port m_valid, output, 1 bit: a sample is available.
REQ-010 The block SHALL have port m_ready, input, 1 bit: the consumer accepts a sample.
REQ-011 The block SHALL have port m_data, output, 5 bits: the mixed sample at FIFO head.
REQ-012 The block SHALL have port level, output, clog2(FIFO_DEPTH)+1 bits: FIFO occupancy.
REQ-013 The block SHALL have port ovf, output, 1 bit: sticky overflow flag.
REQ-014 The block SHALL have port ovf_clr, input, 1 bit: clears ovf.
REQ-015 The block SHALL have port pwm_out, output, 1 bit: 1-bit PWM DAC output.

Function
REQ-016 On sample_tick the block SHALL compute sample = (ch0_bit ? audv0 : 0) + (ch1_bit ? audv1 : 0), zero-extended to 5 bits (range 0..30, no saturation needed), sampling all inputs in the tick cycle.
REQ-017 A computed sample SHALL be pushed into the FIFO at the tick edge; m_valid SHALL rise in the following cycle when the FIFO was empty (1-cycle latency).
REQ-018 The FIFO SHALL be first-word-fall-through: m_data SHALL equal the oldest entry whenever m_valid=1, and SHALL be held stable while m_valid=1 and m_ready=0.
REQ-019 A pop SHALL occur on any edge with m_valid=1 and m_ready=1; m_valid SHALL equal (level != 0).
REQ-020 When tick and pop coincide, both SHALL occur and level SHALL remain unchanged, including at level=FIFO_DEPTH (no overflow).
REQ-021 A tick at level=FIFO_DEPTH without a simultaneous pop SHALL drop the new sample, leave contents unchanged, and set ovf.
REQ-022 ovf SHALL remain set until ovf_clr=1; if ovf_clr and a new overflow coincide, ovf SHALL stay 1.
REQ-023 Read/write pointers SHALL wrap modulo FIFO_DEPTH; level SHALL be kept as a separate counter or as an extra pointer bit.

Reset
REQ-024 While rst=1, the block SHALL force level=0, m_valid=0, m_data=0, ovf=0, pointers=0, pwm_out=0, PWM counter=0, and PWM duty register=0.
REQ-025 Reset asserted mid-operation SHALL discard all FIFO contents; the first tick after release SHALL produce m_valid one cycle later.

Configuration
REQ-026 With macro AUDIO_PWM_EN defined, a 5-bit counter SHALL run 0..29 and wrap to 0.
REQ-027 With AUDIO_PWM_EN defined, a duty register SHALL load the most recently pushed sample at each wrap.
REQ-028 With AUDIO_PWM_EN defined, pwm_out SHALL be registered (counter < duty), giving duty/30 high time.
REQ-029 Without AUDIO_PWM_EN, the port pwm_out SHALL remain present and tied to 0, with no counter or duty logic.

Structure
REQ-030 Package audio_pkg SHALL hold SAMPLE_W=5, VOL_W=4, PWM_PERIOD=30 and typedef sample_t (logic [SAMPLE_W-1:0]).
REQ-031 The FIFO SHALL be the sub-module sample_fifo (push/pop/full/empty/level); the mixer and PWM SHALL reside in the top block.

Verification
REQ-032 The bench SHALL apply ch0_bit=1, audv0=15, ch1_bit=1, audv1=15 with one tick -> m_valid=1 the next cycle, m_data=30.
REQ-033 The bench SHALL apply ch0_bit=1, audv0=7, ch1_bit=0, audv1=9 with one tick -> m_data=7.
REQ-034 The bench SHALL apply 5 ticks with m_ready=0 and depth 4 -> level=4, ovf=1, and pops yield the first 4 samples in order.
REQ-035 The bench SHALL apply a tick together with m_ready=1 at level=4 -> level stays 4, ovf stays 0, and the new sample becomes the tail.
REQ-036 The bench SHALL assert rst with level=3 -> level=0, m_valid=0, ovf=0 immediately, without waiting for a clock edge.
REQ-037 The bench SHALL, with AUDIO_PWM_EN and a pushed sample of 12, observe that pwm_out is high for 12 of every 30 cycles after the next wrap; without the macro pwm_out=0 always.
